// File: rtl/timer_bank.sv
// timer_bank: microsecond time base plus CHANNELS 64-bit compare timers (one-shot or
// periodic auto-reload) behind a zero-wait-state APB slave with pending/enable interrupts.
module timer_bank #(
    parameter int CLK_FREQ   = 48_000_000,
    parameter int TICK_FREQ  = 1_000_000,
    parameter int CHANNELS   = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] apb_PADDR,
    input  logic                  apb_PSEL,
    input  logic                  apb_PENABLE,
    output logic                  apb_PREADY,
    input  logic                  apb_PWRITE,
    input  logic [31:0]           apb_PWDATA,
    output logic [31:0]           apb_PRDATA,
    output logic [63:0]           utime,
    output logic                  utime_tick,
    output logic [CHANNELS-1:0]   irq,
    output logic                  irq_any
);

    localparam int DIV = CLK_FREQ / TICK_FREQ;
    localparam int PW  = $clog2(DIV);
    localparam int BW  = ADDR_WIDTH - 4;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        G_UTIME_LO = 2'd0,
        G_UTIME_HI = 2'd1,
        G_PENDING  = 2'd2,
        G_ENABLE   = 2'd3
    } glb_reg_e;

    typedef enum logic [1:0] {
        C_CMP_LO = 2'd0,
        C_CMP_HI = 2'd1,
        C_PERIOD = 2'd2,
        C_CTRL   = 2'd3
    } ch_reg_e;

    logic [PW-1:0]       prescaler;
    logic [31:0]         snapshot;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] pending_next;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] ch_sel;
    logic [CHANNELS-1:0] ctrl_en;
    logic [CHANNELS-1:0] ctrl_periodic;
    logic [63:0]         cmp    [CHANNELS];
    logic [31:0]         shadow [CHANNELS];
    logic [31:0]         period [CHANNELS];
    logic [31:0]         rdata;
    logic [BW-1:0]       blk;
    logic                aligned;
    logic                glb_sel;
    logic                wr_en;
    logic                snap_en;
    glb_reg_e            glb_word;
    ch_reg_e             ch_word;

    // Each 16-byte block is one register group: block 0 is global, block i+1 is channel i.
    assign blk      = apb_PADDR[ADDR_WIDTH-1:4];
    assign aligned  = (apb_PADDR[1:0] == 2'b00);
    assign glb_sel  = aligned && (blk == '0);
    assign glb_word = glb_reg_e'(apb_PADDR[3:2]);
    assign ch_word  = ch_reg_e'(apb_PADDR[3:2]);
    assign wr_en    = apb_PSEL & apb_PENABLE & apb_PWRITE;
    assign snap_en  = apb_PSEL & ~apb_PENABLE & ~apb_PWRITE & glb_sel & (glb_word == G_UTIME_LO);

    assign apb_PREADY = 1'b1;

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_sel[i] = aligned && (blk == BW'(i + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            prescaler  <= '0;
            utime      <= '0;
            utime_tick <= 1'b0;
        end else if (prescaler == PRESC_LAST) begin
            prescaler  <= '0;
            utime      <= utime + 64'd1;
            utime_tick <= 1'b1;
        end else begin
            prescaler  <= prescaler + PW'(1);
            utime_tick <= 1'b0;
        end
    end

    // Compare against the registered utime, so a match lands one cycle after utime gets there.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = ctrl_en[i] && (utime >= cmp[i]);
        end
    end

    always_comb begin
        pending_next = pending;
        if (wr_en && glb_sel && (glb_word == G_PENDING)) begin
            pending_next = pending & ~apb_PWDATA[CHANNELS-1:0];
        end
        pending_next = pending_next | hit;
    end

    // Hit updates come first so a same-cycle APB write to CMP_HI/CTRL overrides them.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cmp[i]    <= '1;
                shadow[i] <= '0;
                period[i] <= '0;
            end
            ctrl_en       <= '0;
            ctrl_periodic <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i]) begin
                    if (ctrl_periodic[i] && (period[i] != 32'd0)) begin
                        cmp[i] <= cmp[i] + {32'd0, period[i]};
                    end else begin
                        ctrl_en[i] <= 1'b0;
                    end
                end
                if (wr_en && ch_sel[i]) begin
                    case (ch_word)
                        C_CMP_LO: shadow[i] <= apb_PWDATA;
                        C_CMP_HI: cmp[i]    <= {apb_PWDATA, shadow[i]};
                        C_PERIOD: period[i] <= apb_PWDATA;
                        default: begin
                            ctrl_en[i]       <= apb_PWDATA[0];
                            ctrl_periodic[i] <= apb_PWDATA[1];
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pending <= '0;
            enable  <= '0;
            irq     <= '0;
            irq_any <= 1'b0;
        end else begin
            pending <= pending_next;
            if (wr_en && glb_sel && (glb_word == G_ENABLE)) begin
                enable <= apb_PWDATA[CHANNELS-1:0];
            end
            irq     <= pending & enable;
            irq_any <= |(pending & enable);
        end
    end

    always_comb begin
        rdata = '0;
        if (glb_sel) begin
            case (glb_word)
                G_UTIME_LO: rdata = utime[31:0];
                G_UTIME_HI: rdata = snapshot;
                G_PENDING:  rdata = 32'(pending);
                default:    rdata = 32'(enable);
            endcase
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_sel[i]) begin
                    case (ch_word)
                        C_CMP_LO: rdata = cmp[i][31:0];
                        C_CMP_HI: rdata = cmp[i][63:32];
                        C_PERIOD: rdata = period[i];
                        default:  rdata = {30'd0, ctrl_periodic[i], ctrl_en[i]};
                    endcase
                end
            end
        end
    end

    // Snapshot of the upper word is taken in the UTIME_LO setup phase so the pair never tears.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            snapshot   <= '0;
            apb_PRDATA <= '0;
        end else begin
            if (snap_en) begin
                snapshot <= utime[63:32];
            end
            if (apb_PSEL) begin
                apb_PRDATA <= rdata;
            end
        end
    end

endmodule
